// File: rtl/mips_alu_pkg.sv
// Shared constants for the MIPS32 EX-stage ALU: datapath width and aluop encodings.
// The unsigned opcodes are always declared here; they are only decoded when MIPS_ALU_UNSIGNED_EN is defined.
package mips_alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_SUBU = 6'b100011;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_NOR  = 6'b100111;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SLTU = 6'b101011;
  localparam logic [5:0] ALU_LUI  = 6'b101111;
  localparam logic [5:0] ALU_SLL  = 6'b000000;
  localparam logic [5:0] ALU_SRL  = 6'b000010;
  localparam logic [5:0] ALU_SRA  = 6'b000011;
  localparam logic [5:0] ALU_SLLV = 6'b000100;
  localparam logic [5:0] ALU_SRLV = 6'b000110;
  localparam logic [5:0] ALU_SRAV = 6'b000111;

endpackage

// File: rtl/mips_alu_if.sv
// Operand/opcode/result bundle between the EX-stage control and the ALU.
// The master drives operands and opcode; the slave (the ALU) drives the registered results.
interface mips_alu_if;
  import mips_alu_pkg::*;

  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic [5:0]       aluop;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] ALU_out;
  logic             overflow_out;
  logic             zero_out;

  modport master (
    output A_in, B_in, aluop, shamt,
    input  ALU_out, overflow_out, zero_out
  );

  modport slave (
    input  A_in, B_in, aluop, shamt,
    output ALU_out, overflow_out, zero_out
  );

endinterface

// File: rtl/mips_alu_shifter.sv
// Combinational 32-bit barrel shifter: dir=0 shifts left, dir=1 shifts right,
// and arith selects sign fill for right shifts.
module mips_alu_shifter
  import mips_alu_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  input  logic [4:0]       amount,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data << amount;
    if (dir) begin
      if (arith) result = WIDTH'($signed(data) >>> amount);
      else       result = data >> amount;
    end
  end

endmodule

// File: rtl/mips_alu.sv
// MIPS32 EX-stage ALU with registered result, overflow and zero flags (one-cycle latency).
// Define MIPS_ALU_UNSIGNED_EN to also decode ADDU, SUBU and SLTU.
module mips_alu
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mips_alu_if.slave   bus
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] shift_out;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             add_ovf;
  logic             sub_ovf;
  logic [4:0]       shift_amt;

  assign sum  = bus.A_in + bus.B_in;
  assign diff = bus.A_in - bus.B_in;

  assign add_ovf = (bus.A_in[WIDTH-1] == bus.B_in[WIDTH-1]) && (sum[WIDTH-1]  != bus.A_in[WIDTH-1]);
  assign sub_ovf = (bus.A_in[WIDTH-1] != bus.B_in[WIDTH-1]) && (diff[WIDTH-1] != bus.A_in[WIDTH-1]);

  // aluop[2] marks the variable-shift group; [1] is right vs left, [0] is arithmetic.
  assign shift_amt = bus.aluop[2] ? bus.B_in[4:0] : bus.shamt;

  mips_alu_shifter u_shifter (
    .data   (bus.A_in),
    .amount (shift_amt),
    .dir    (bus.aluop[1]),
    .arith  (bus.aluop[0]),
    .result (shift_out)
  );

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (bus.aluop)
      ALU_ADD: begin
        result = sum;
        ovf    = add_ovf;
      end
      ALU_SUB: begin
        result = diff;
        ovf    = sub_ovf;
      end
      ALU_AND: result = bus.A_in & bus.B_in;
      ALU_OR:  result = bus.A_in | bus.B_in;
      ALU_XOR: result = bus.A_in ^ bus.B_in;
      ALU_NOR: result = ~(bus.A_in | bus.B_in);
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(bus.A_in) < $signed(bus.B_in))};
      ALU_LUI: result = {bus.B_in[15:0], 16'h0000};
      ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLLV, ALU_SRLV, ALU_SRAV: result = shift_out;
`ifdef MIPS_ALU_UNSIGNED_EN
      ALU_ADDU: result = sum;
      ALU_SUBU: result = diff;
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (bus.A_in < bus.B_in)};
`else
`endif
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ALU_out      <= '0;
      bus.overflow_out <= 1'b0;
      bus.zero_out     <= 1'b1;
    end else begin
      bus.ALU_out      <= result;
      bus.overflow_out <= ovf;
      bus.zero_out     <= ~|result;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed steps push expectations into a scoreboard
// queue, and each registered result is popped and compared one cycle later.
module tb_mips_alu;
  import mips_alu_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   compared;
  int   mismatched;

  mips_alu_if bus ();

  mips_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushExpect(input string tag, input logic [31:0] res, input logic ovf);
    exp_t e;
    e.tag  = tag;
    e.res  = res;
    e.ovf  = ovf;
    e.zero = (res == 32'h0);
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh,
                               input logic [31:0] eres, input logic eovf);
    bus.aluop = op;
    bus.A_in  = a;
    bus.B_in  = b;
    bus.shamt = sh;
    pushExpect(tag, eres, eovf);
  endtask

  task automatic checkOutput();
    exp_t e;
    compared++;
    assert (sb.size() > 0)
    else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      assert (bus.ALU_out === e.res)
      else begin
        mismatched++;
        $error("[TB] FAIL %s.result: observed %h expected %h", e.tag, bus.ALU_out, e.res);
      end
      compared++;
      assert (bus.overflow_out === e.ovf)
      else begin
        mismatched++;
        $error("[TB] FAIL %s.overflow: observed %b expected %b", e.tag, bus.overflow_out, e.ovf);
      end
      compared++;
      assert (bus.zero_out === e.zero)
      else begin
        mismatched++;
        $error("[TB] FAIL %s.zero: observed %b expected %b", e.tag, bus.zero_out, e.zero);
      end
    end
  endtask

  task automatic step(input string tag, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh,
                      input logic [31:0] eres, input logic eovf);
    applyStimulus(tag, op, a, b, sh, eres, eovf);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [31:0] ra, rb, rs;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    bus.aluop  = ALU_ADD;
    bus.A_in   = 32'h16;
    bus.B_in   = 32'h0F;
    bus.shamt  = 5'd3;

    // Reset holds outputs cleared for two edges even with a live ADD on the inputs.
    @(negedge clk);
    @(negedge clk);
    pushExpect("reset", 32'h0, 1'b0);
    checkOutput();

    rst = 1'b0;
    step("first_add", ALU_ADD, 32'h16, 32'h0F, 5'd0, 32'h25, 1'b0);

    step("sub",  ALU_SUB, 32'h16, 32'h0F, 5'd0, 32'h07,       1'b0);
    step("and",  ALU_AND, 32'h16, 32'h0F, 5'd0, 32'h06,       1'b0);
    step("or",   ALU_OR,  32'h16, 32'h0F, 5'd0, 32'h1F,       1'b0);
    step("xor",  ALU_XOR, 32'h16, 32'h0F, 5'd0, 32'h19,       1'b0);
    step("nor",  ALU_NOR, 32'h16, 32'h0F, 5'd0, 32'hFFFFFFE0, 1'b0);
    step("slt",  ALU_SLT, 32'h16, 32'h0F, 5'd0, 32'h0,        1'b0);
    step("lui",  ALU_LUI, 32'h16, 32'h0F, 5'd0, 32'h000F0000, 1'b0);

    step("sll",  ALU_SLL, 32'hFF00F000, 32'hFFFFFFE3, 5'd6, 32'hC03C0000, 1'b0);
    step("srl",  ALU_SRL, 32'hFF00F000, 32'hFFFFFFE3, 5'd6, 32'h03FC03C0, 1'b0);
    step("sra",  ALU_SRA, 32'hFF00F000, 32'hFFFFFFE3, 5'd6, 32'hFFFC03C0, 1'b0);
    step("sll0", ALU_SLL, 32'hFF00F000, 32'h0,        5'd0, 32'hFF00F000, 1'b0);

    step("sllv", ALU_SLLV, 32'hFF00F000, 32'hFFFFFF0F, 5'd2, 32'h78000000, 1'b0);
    step("srlv", ALU_SRLV, 32'hFF00F000, 32'h0000000F, 5'd2, 32'h0001FE01, 1'b0);
    step("srav", ALU_SRAV, 32'hFF00F000, 32'h0000000F, 5'd2, 32'hFFFFFE01, 1'b0);
    step("srav0",ALU_SRAV, 32'hFF00F000, 32'hFFFFFFE0, 5'd7, 32'hFF00F000, 1'b0);

    step("add_ovf",  ALU_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1);
    step("sub_ovf",  ALU_SUB, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1);
    step("sub_zero", ALU_SUB, 32'h5,        32'h5, 5'd0, 32'h0,        1'b0);
    step("slt_neg",  ALU_SLT, 32'h80000000, 32'h1, 5'd0, 32'h1,        1'b0);
    step("slt_wrap", ALU_SLT, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0);
    step("bad_op",   6'h3F,   32'h12345678, 32'h9, 5'd4, 32'h0,        1'b0);

`ifdef MIPS_ALU_UNSIGNED_EN
    step("sltu",     ALU_SLTU, 32'h80000000, 32'h1, 5'd0, 32'h0,        1'b0);
    step("addu",     ALU_ADDU, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0);
    step("subu",     ALU_SUBU, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b0);
`else
    step("sltu_off", ALU_SLTU, 32'h80000000, 32'h1, 5'd0, 32'h0, 1'b0);
    step("addu_off", ALU_ADDU, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0);
    step("subu_off", ALU_SUBU, 32'h80000000, 32'h1, 5'd0, 32'h0, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = ra + rb;
      step("rand_add", ALU_ADD, ra, rb, 5'd0, rs, (ra[31] == rb[31]) && (rs[31] != ra[31]));
      step("rand_xor", ALU_XOR, ra, rb, 5'd0, ra ^ rb, 1'b0);
    end

    // Reset mid-stream must override the operation presented on the same edge.
    applyStimulus("reset_mid", ALU_NOR, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit integer ALU for the MIPS32 single-issue datapath, located in the EX stage.
- Function is selected by the 6-bit MIPS funct-style code `aluop`.
- Covers add/sub, logic, signed set-less-than, LUI, and fixed/variable shifts.
- Result, overflow and zero flags are registered: one-cycle latency.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported, and shift amounts are 5 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- A_in  in  32  operand A (rs); data operand for all shifts.
- B_in  in  32  operand B (rt/immediate); B_in[4:0] is the variable shift amount.
- aluop  in  6  operation select.
- shamt  in  5  fixed shift amount for SLL/SRL/SRA.
- ALU_out  out  32  registered result.
- overflow_out  out  1  registered signed-overflow flag.
- zero_out  out  1  registered flag; 1 when the registered result is all zeros.

Behaviour:
- Combinational result is computed from the current inputs and captured every rising clk edge. Outputs reflect the inputs of the previous cycle.
- On rst=1 at a clock edge: ALU_out=0, overflow_out=0, zero_out=1. Reset has priority over any operation in flight.
- Opcodes (binary -> result):
  - 100000 ADD: A+B, modulo 2^32.
  - 100010 SUB: A-B, modulo 2^32.
  - 100100 AND: A&B.
  - 100101 OR: A|B.
  - 100110 XOR: A^B.
  - 100111 NOR: ~(A|B).
  - 101010 SLT: 32'd1 if signed(A) < signed(B), else 0. Computed correctly even when A-B overflows.
  - 101111 LUI: {B[15:0], 16'h0000}.
  - 000000 SLL: A << shamt.
  - 000010 SRL: A >> shamt, logical.
  - 000011 SRA: A >>> shamt, arithmetic (sign-filled).
  - 000100 SLLV: A << B[4:0].
  - 000110 SRLV: A >> B[4:0], logical.
  - 000111 SRAV: A >>> B[4:0], arithmetic.
- Overflow:
  - ADD: overflow=1 when A and B have the same sign and the result sign differs.
  - SUB: overflow=1 when A and B have different signs and the result sign differs from A.
  - All other ops: overflow=0.
  - The result is still written even when overflow is flagged.
- zero_out: NOR-reduction of the combinational result, registered alongside ALU_out.
- Any unlisted aluop gives result 0, overflow 0, zero 1.
- A shift amount of 0 passes A unchanged. Upper bits of B_in are ignored for variable shifts.

Optional Feature:
- Macro: MIPS_ALU_UNSIGNED_EN.
- When defined, three extra opcodes are decoded:
  - 100001 ADDU: A+B, overflow forced 0.
  - 100011 SUBU: A-B, overflow forced 0.
  - 101011 SLTU: 1 if unsigned A < unsigned B, else 0.
- When undefined, these three codes take the unlisted-opcode behaviour (result 0, overflow 0, zero 1).

Decomposition:
- Package mips_alu_pkg holds:
  - localparams for all aluop codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV, plus the unsigned codes);
  - the WIDTH constant.
- One sub-module, mips_alu_shifter: combinational 32-bit barrel shifter.
  - Inputs: data, 5-bit amount, dir (left/right), arith.
  - The top-level selects shamt or B_in[4:0] as the amount.

Test Plan:
1. rst=1 for 2 cycles with nonzero inputs -> ALU_out=0, overflow_out=0, zero_out=1. Deassert rst -> the first result appears one cycle later.
2. Arithmetic and logic, A=0x16, B=0x0F, one opcode per cycle -> results one cycle later:
   - ADD 0x25; SUB 0x07; AND 0x06; OR 0x1F;
   - XOR 0x19; NOR 0xFFFFFFE0; SLT 0; LUI 0x000F0000.
3. Fixed shifts, A=0xFF00F000, shamt=6 -> SLL 0xC03C0000; SRL 0x03FC03C0; SRA 0xFFFC03C0.
4. Variable shifts, A=0xFF00F000, B=0x0F (amount 15) -> SLLV 0x78000000; SRLV 0x0001FE01; SRAV 0xFFFFFE01.
5. Overflow and zero:
   - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow 1.
   - SUB 0x80000000-1 -> 0x7FFFFFFF, overflow 1.
   - SUB 5-5 -> 0, zero 1, overflow 0.
   - SLT 0x80000000 vs 1 -> 1.
6. Unlisted aluop 0x3F -> result 0, zero 1. With MIPS_ALU_UNSIGNED_EN: SLTU 0x80000000 vs 1 -> 0, and ADDU 0x7FFFFFFF+1 -> overflow 0.
